// File: rtl/spi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spi_pkg : shared types and constants for the SPI response transmit path      |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
package spi_pkg;

  localparam int          BYTE_W            = 8;
  localparam logic [7:0]  DEFAULT_IDLE_BYTE = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sync_fifo : single-clock FIFO, head visible on o_dout, registered count      |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_din,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rptr];

  // A push into a full FIFO is dropped even if a pop happens the same cycle.
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop  && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= AW'(r_wptr + 1'b1);
      if (w_pop)  r_rptr <= AW'(r_rptr + 1'b1);
      case ({w_push, w_pop})
        2'b10:   r_count <= (AW+1)'(r_count + 1'b1);
        2'b01:   r_count <= (AW+1)'(r_count - 1'b1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_resp_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spi_resp_tx : SPI mode-0 slave transmitter, MSB first, FIFO-buffered bytes   |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module spi_resp_tx
  import spi_pkg::*;
#(
  parameter int                FIFO_DEPTH = 4,
  parameter logic [BYTE_W-1:0] IDLE_BYTE  = DEFAULT_IDLE_BYTE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic [BYTE_W-1:0] char_in,
  output logic              ready_out,
  input  logic              sclk,
  input  logic              cs_n,
  output logic              miso,
  output logic              miso_oe,
  output logic              overflow,
  output logic              underflow
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [2:0]        r_sclk_q;
  logic [2:0]        r_csn_q;
  logic              w_rise_sclk;
  logic              w_fall_sclk;
  logic              w_fall_cs;
  logic              w_rise_cs;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [BYTE_W-1:0] r_shift;
  logic [BYTE_W-1:0] w_shift_nxt;
  logic [3:0]        r_cnt;
  logic [3:0]        w_cnt_nxt;
  logic              r_miso;
  logic              w_miso_nxt;
  logic              r_oe;
  logic              w_oe_nxt;
  logic              r_overflow;
  logic              r_underflow;
  logic              w_underflow;
  logic              w_load;
  logic              w_pop;

  logic [BYTE_W-1:0] w_head;
  logic              w_full;
  logic              w_empty;
  logic [CW-1:0]     w_count;

  sync_fifo #(
    .WIDTH (BYTE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (valid_in),
    .i_din   (char_in),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Two metastability flops, third stage only for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sclk_q <= 3'b000;
      r_csn_q  <= 3'b111;
    end else begin
      r_sclk_q <= {r_sclk_q[1:0], sclk};
      r_csn_q  <= {r_csn_q[1:0], cs_n};
    end
  end

  assign w_rise_sclk =  r_sclk_q[1] & ~r_sclk_q[2];
  assign w_fall_sclk = ~r_sclk_q[1] &  r_sclk_q[2];
  assign w_fall_cs   = ~r_csn_q[1]  &  r_csn_q[2];
  assign w_rise_cs   =  r_csn_q[1]  & ~r_csn_q[2];

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    w_miso_nxt  = r_miso;
    w_oe_nxt    = r_oe;
    w_pop       = 1'b0;
    w_underflow = 1'b0;
    w_load      = 1'b0;

    case (r_state)
      IDLE: begin
        w_miso_nxt = 1'b0;
        w_oe_nxt   = 1'b0;
        if (w_fall_cs) w_state_nxt = LOAD;
      end
      LOAD: w_load = 1'b1;
      SHIFT: begin
        if (w_rise_sclk) begin
          if (r_cnt != 4'd8) w_cnt_nxt = r_cnt + 4'd1;
        end else if (w_fall_sclk) begin
          if (r_cnt == 4'd8) begin
            w_load = 1'b1;
          end else begin
            w_shift_nxt = {r_shift[BYTE_W-2:0], 1'b0};
            w_miso_nxt  = r_shift[BYTE_W-2];
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    if (w_load) begin
      w_pop       = !w_empty;
      w_underflow = w_empty;
      w_shift_nxt = w_empty ? IDLE_BYTE : w_head;
      w_miso_nxt  = w_shift_nxt[BYTE_W-1];
      w_oe_nxt    = 1'b1;
      w_cnt_nxt   = 4'd0;
      w_state_nxt = SHIFT;
    end

    // Deselect overrides everything, including a coincident SCLK edge.
    if (w_rise_cs) begin
      w_state_nxt = IDLE;
      w_miso_nxt  = 1'b0;
      w_oe_nxt    = 1'b0;
      w_cnt_nxt   = 4'd0;
      w_pop       = 1'b0;
      w_underflow = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_cnt       <= 4'd0;
      r_miso      <= 1'b0;
      r_oe        <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_shift     <= w_shift_nxt;
      r_cnt       <= w_cnt_nxt;
      r_miso      <= w_miso_nxt;
      r_oe        <= w_oe_nxt;
      r_overflow  <= valid_in && w_full;
      r_underflow <= w_underflow;
    end
  end

  assign miso      = r_miso;
  assign miso_oe   = r_oe;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;
  assign ready_out = (w_count < CW'(FIFO_DEPTH));

endmodule
`default_nettype wire

// File: tb/tb_spi_resp_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_spi_resp_tx : directed bench acting as producer and SPI mode-0 master     |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module tb_spi_resp_tx;

  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid_in = 1'b0;
  logic [7:0] char_in = 8'h00;
  logic       ready_out;
  logic       sclk = 1'b0;
  logic       cs_n = 1'b1;
  logic       miso;
  logic       miso_oe;
  logic       overflow;
  logic       underflow;

  int n_pass  = 0;
  int n_total = 0;
  int uf_cnt  = 0;
  int ov_cnt  = 0;

  spi_resp_tx #(
    .FIFO_DEPTH (4),
    .IDLE_BYTE  (8'hFF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .char_in   (char_in),
    .ready_out (ready_out),
    .sclk      (sclk),
    .cs_n      (cs_n),
    .miso      (miso),
    .miso_oe   (miso_oe),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (underflow) uf_cnt++;
    if (overflow)  ov_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_byte(input logic [7:0] b);
    valid_in = 1'b1;
    char_in  = b;
    wait_clk(1);
    valid_in = 1'b0;
  endtask

  // Master samples MISO as it raises SCLK; the final falling edge coincides with deselect.
  task automatic run_frame(input int nbytes, output logic [31:0] rx, output logic oe_ok);
    rx    = '0;
    oe_ok = 1'b1;
    cs_n  = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < nbytes * 8; i++) begin
      sclk  = 1'b1;
      rx    = {rx[30:0], miso};
      oe_ok = oe_ok & miso_oe;
      wait_clk(HALF);
      if (i == nbytes * 8 - 1) cs_n = 1'b1;
      sclk = 1'b0;
      wait_clk(HALF);
    end
    wait_clk(HALF);
  endtask

  initial begin
    logic [31:0] rx;
    logic        oe_ok;
    int          uf0;
    int          ov0;

    wait_clk(3);
    check("reset_miso",      32'(miso),      32'd0);
    check("reset_miso_oe",   32'(miso_oe),   32'd0);
    check("reset_ready",     32'(ready_out), 32'd1);
    check("reset_overflow",  32'(overflow),  32'd0);
    check("reset_underflow", 32'(underflow), 32'd0);
    rst = 1'b0;
    wait_clk(4);

    // Single byte 0x62: bits 0,1,1,0,0,0,1,0.
    push_byte(8'h62);
    wait_clk(2);
    uf0 = uf_cnt;
    run_frame(1, rx, oe_ok);
    check("b62_rx",       rx,               32'h62);
    check("b62_oe_frame", 32'(oe_ok),       32'd1);
    check("b62_oe_after", 32'(miso_oe),     32'd0);
    check("b62_miso_aft", 32'(miso),        32'd0);
    check("b62_underflow", 32'(uf_cnt - uf0), 32'd0);

    // Back-to-back bytes under one CS_N assertion.
    push_byte(8'h62);
    push_byte(8'h63);
    wait_clk(2);
    uf0 = uf_cnt;
    run_frame(2, rx, oe_ok);
    check("b2_rx",        rx,               32'h6263);
    check("b2_underflow", 32'(uf_cnt - uf0), 32'd0);

    // Empty FIFO sends the idle byte with a single underflow.
    uf0 = uf_cnt;
    run_frame(1, rx, oe_ok);
    check("empty_rx",        rx,               32'hFF);
    check("empty_underflow", 32'(uf_cnt - uf0), 32'd1);

    // Overfill: fifth byte dropped.
    ov0 = ov_cnt;
    for (int i = 0; i < 5; i++) begin
      valid_in = 1'b1;
      char_in  = 8'(8'h11 * (i + 1));
      wait_clk(1);
      if (i == 3) check("ovf_ready_after4", 32'(ready_out), 32'd0);
    end
    valid_in = 1'b0;
    wait_clk(3);
    check("ovf_pulses",      32'(ov_cnt - ov0), 32'd1);
    check("ovf_ready_still", 32'(ready_out),    32'd0);
    uf0 = uf_cnt;
    run_frame(4, rx, oe_ok);
    check("ovf_drain_rx",    rx,               32'h11223344);
    check("ovf_drain_uf",    32'(uf_cnt - uf0), 32'd0);
    check("ovf_drain_ready", 32'(ready_out),    32'd1);

    // Abort after 3 bits of 0x63; 0x62 queued behind it.
    push_byte(8'h63);
    push_byte(8'h62);
    wait_clk(2);
    rx   = '0;
    cs_n = 1'b0;
    wait_clk(HALF);
    for (int k = 0; k < 3; k++) begin
      sclk = 1'b1;
      rx   = {rx[30:0], miso};
      wait_clk(HALF);
      if (k < 2) begin
        sclk = 1'b0;
        wait_clk(HALF);
      end
    end
    check("abort_rx3",      rx,           32'h3);
    check("abort_miso_pre", 32'(miso),    32'd1);
    cs_n = 1'b1;
    wait_clk(4);
    check("abort_miso",    32'(miso),    32'd0);
    check("abort_miso_oe", 32'(miso_oe), 32'd0);
    sclk = 1'b0;
    wait_clk(HALF);
    uf0 = uf_cnt;
    run_frame(1, rx, oe_ok);
    check("abort_next_rx", rx,               32'h62);
    check("abort_next_uf", 32'(uf_cnt - uf0), 32'd0);

    // Asynchronous reset mid-frame with the FIFO full.
    push_byte(8'hA1);
    push_byte(8'hA2);
    push_byte(8'hA3);
    push_byte(8'hA4);
    cs_n = 1'b0;
    wait_clk(HALF);
    push_byte(8'hA5);
    wait_clk(2);
    check("arst_ready_pre", 32'(ready_out), 32'd0);
    check("arst_miso_pre",  32'(miso),      32'd1);
    check("arst_oe_pre",    32'(miso_oe),   32'd1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_miso",  32'(miso),      32'd0);
    check("arst_oe",    32'(miso_oe),   32'd0);
    check("arst_ready", 32'(ready_out), 32'd1);
    cs_n = 1'b1;
    wait_clk(2);
    rst = 1'b0;
    wait_clk(HALF);
    uf0 = uf_cnt;
    run_frame(1, rx, oe_ok);
    check("arst_next_rx", rx,               32'hFF);
    check("arst_next_uf", 32'(uf_cnt - uf0), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
